// File: rtl/warp_issue_arbiter.sv
// Warp issue unit: round-robin issue grant and fixed-priority exit grant per cycle,
// with live-warp tracking from kernel launch to completion.
module warp_issue_arbiter #(
  parameter int NUM_WARPS = 8,
  parameter int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Launch_IU,
  input  logic [NUM_WARPS-1:0] Launch_Mask_IU,
  input  logic [NUM_WARPS-1:0] Req_IB_IU,
  output logic [NUM_WARPS-1:0] Grt_IU_IB,
  input  logic [NUM_WARPS-1:0] Exit_Req_IB_IU,
  output logic [NUM_WARPS-1:0] Exit_Grt_IU_IB,
  output logic                 Issue_Valid_IU_OC,
  output logic [WID_W-1:0]     Issue_WarpID_IU_OC,
  output logic [NUM_WARPS-1:0] Active_Warps_IU,
  output logic                 Busy_IU,
  output logic                 Done_IU,
  output logic [15:0]          Issue_Cnt_IU
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_WARPS-1:0] active_q, active_d;
  logic [WID_W-1:0]     ptr_q, ptr_d;
  logic [15:0]          cnt_q, cnt_d;

  logic [NUM_WARPS-1:0] elig, eligx;
  logic [NUM_WARPS-1:0] grt, xgrt;
  logic [WID_W-1:0]     gid;
  logic                 found, xfound;
  logic [WID_W-1:0]     idx;
  logic                 run;

  assign run = (state_q == S_RUN);

  // A warp asking to exit is withheld from issue, so it only ever sees the exit grant.
  always_comb begin
    eligx = Exit_Req_IB_IU & active_q & {NUM_WARPS{run}};
    elig  = Req_IB_IU & active_q & ~Exit_Req_IB_IU & {NUM_WARPS{run}};
  end

  always_comb begin
    grt   = '0;
    gid   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      idx = ptr_q + WID_W'(i);
      if (!found && elig[idx]) begin
        found    = 1'b1;
        grt[idx] = 1'b1;
        gid      = idx;
      end
    end
  end

  always_comb begin
    xgrt   = '0;
    xfound = 1'b0;
    for (int unsigned i = 0; i < NUM_WARPS; i++) begin
      if (!xfound && eligx[WID_W'(i)]) begin
        xfound            = 1'b1;
        xgrt[WID_W'(i)]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Launch_IU && (Launch_Mask_IU != '0)) begin
          state_d  = S_RUN;
          active_d = Launch_Mask_IU;
          ptr_d    = '0;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        active_d = active_q & ~xgrt;
        if (found) begin
          ptr_d = gid + WID_W'(1);
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        end
        if (active_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      active_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Grt_IU_IB          = grt;
  assign Exit_Grt_IU_IB     = xgrt;
  assign Issue_Valid_IU_OC  = |grt;
  assign Issue_WarpID_IU_OC = gid;
  assign Active_Warps_IU    = active_q;
  assign Busy_IU            = run;
  assign Done_IU            = (state_q == S_DONE);
  assign Issue_Cnt_IU       = cnt_q;

endmodule

// File: tb/tb_warp_issue_arbiter.sv
// Directed scoreboard bench for warp_issue_arbiter: hand-derived expectations queued
// as each cycle's stimulus is driven, popped and compared mid-cycle.
module tb_warp_issue_arbiter;

  logic       clk;
  logic       rst;
  logic       launch;
  logic [7:0] lmask, req, xreq;
  logic [7:0] grt, xgrt, act;
  logic       valid, busy, done;
  logic [2:0] wid;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  grt;
    logic [7:0]  xgrt;
    logic [7:0]  act;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  warp_issue_arbiter #(.NUM_WARPS(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .Launch_IU          (launch),
    .Launch_Mask_IU     (lmask),
    .Req_IB_IU          (req),
    .Grt_IU_IB          (grt),
    .Exit_Req_IB_IU     (xreq),
    .Exit_Grt_IU_IB     (xgrt),
    .Issue_Valid_IU_OC  (valid),
    .Issue_WarpID_IU_OC (wid),
    .Active_Warps_IU    (act),
    .Busy_IU            (busy),
    .Done_IU            (done),
    .Issue_Cnt_IU       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic [7:0] g, input logic [7:0] xg, input logic [7:0] a,
                          input logic b, input logic d, input logic [15:0] c);
    exp_t e;
    e.grt = g; e.xgrt = xg; e.act = a; e.busy = b; e.done = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic compare_front(input string tag);
    exp_t e;
    logic [2:0] ew;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e  = exp_q.pop_front();
    ew = '0;
    for (int i = 0; i < 8; i++) if (e.grt[i]) ew = 3'(i);
    chk({tag, "_grt"},   {24'd0, grt},  {24'd0, e.grt});
    chk({tag, "_xgrt"},  {24'd0, xgrt}, {24'd0, e.xgrt});
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, |e.grt});
    chk({tag, "_wid"},   {29'd0, wid},  {29'd0, ew});
    chk({tag, "_act"},   {24'd0, act},  {24'd0, e.act});
    chk({tag, "_busy"},  {31'd0, busy}, {31'd0, e.busy});
    chk({tag, "_done"},  {31'd0, done}, {31'd0, e.done});
    chk({tag, "_cnt"},   {16'd0, cnt},  {16'd0, e.cnt});
  endtask

  // One clock cycle: drive at posedge+1, sample at the following negedge.
  task automatic cyc(input string tag, input logic l, input logic [7:0] m,
                     input logic [7:0] r, input logic [7:0] x,
                     input logic [7:0] g, input logic [7:0] xg, input logic [7:0] a,
                     input logic b, input logic d, input logic [15:0] c);
    launch = l; lmask = m; req = r; xreq = x;
    push_exp(g, xg, a, b, d, c);
    @(negedge clk);
    compare_front(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    launch = 1'b0; lmask = '0; req = '0; xreq = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
    compare_front("reset");
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // Launch 0x0F, then round-robin over four requesters.
    cyc("launch1", 1, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd0);
    for (int k = 0; k < 8; k++)
      cyc("rr", 0, 8'h00, 8'h0F, 8'h00, 8'(1 << (k % 4)), 8'h00, 8'h0F, 1, 0, 16'(k));
    cyc("cnt8", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 1, 0, 16'd8);

    // Exit priority, lowest first, then DONE pulse and IDLE.
    cyc("ex0", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 8'h0F, 1, 0, 16'd8);
    cyc("ex1", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h02, 8'h0E, 1, 0, 16'd8);
    cyc("ex2", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h04, 8'h0C, 1, 0, 16'd8);
    cyc("ex3", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h08, 8'h08, 1, 0, 16'd8);
    cyc("done1", 0, 8'h00, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 1, 16'd8);
    cyc("launch2", 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd8);

    // Move pointer to 6, then 0x81 requests: 7, 0 (wrap), 7.
    cyc("ptr6", 0, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'hFF, 1, 0, 16'd0);
    cyc("wrap7a", 0, 8'h00, 8'h81, 8'h00, 8'h80, 8'h00, 8'hFF, 1, 0, 16'd1);
    cyc("wrap0", 0, 8'h00, 8'h81, 8'h00, 8'h01, 8'h00, 8'hFF, 1, 0, 16'd2);
    cyc("wrap7b", 0, 8'h00, 8'h81, 8'h00, 8'h80, 8'h00, 8'hFF, 1, 0, 16'd3);

    // Exits of warps 4..7 alongside independent issue to warp 0.
    cyc("exiss4", 0, 8'h00, 8'h01, 8'hF0, 8'h01, 8'h10, 8'hFF, 1, 0, 16'd4);
    cyc("exiss5", 0, 8'h00, 8'h01, 8'hF0, 8'h01, 8'h20, 8'hEF, 1, 0, 16'd5);
    cyc("exiss6", 0, 8'h00, 8'h01, 8'hF0, 8'h01, 8'h40, 8'hCF, 1, 0, 16'd6);
    cyc("exiss7", 0, 8'h00, 8'h01, 8'hF0, 8'h01, 8'h80, 8'h8F, 1, 0, 16'd7);

    // Requests from inactive warps and a launch while running are both ignored.
    cyc("inact", 1, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h0F, 1, 0, 16'd8);
    cyc("runlnch", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 1, 0, 16'd8);
    cyc("ex0b", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h01, 8'h0F, 1, 0, 16'd8);
    cyc("ex1b", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h02, 8'h0E, 1, 0, 16'd8);
    cyc("ex2b", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h04, 8'h0C, 1, 0, 16'd8);
    cyc("ex3b", 0, 8'h00, 8'h00, 8'h0F, 8'h00, 8'h08, 8'h08, 1, 0, 16'd8);
    cyc("done2", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 16'd8);
    cyc("zmask", 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd8);
    cyc("launch3", 1, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd8);

    // Issue to 0 and exit of 1 in the same cycle, then final exit of 0.
    cyc("isx", 0, 8'h00, 8'h01, 8'h02, 8'h01, 8'h02, 8'h03, 1, 0, 16'd0);
    cyc("act01", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 16'd1);
    cyc("lastex", 0, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 1, 0, 16'd1);
    cyc("done3", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 16'd1);
    cyc("launch4", 1, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd1);

    // Simultaneous exits of 1 and 2 serialise; DONE only after both.
    cyc("sx1", 0, 8'h00, 8'h00, 8'h06, 8'h00, 8'h02, 8'h06, 1, 0, 16'd0);
    cyc("sx2", 0, 8'h00, 8'h00, 8'h06, 8'h00, 8'h04, 8'h04, 1, 0, 16'd0);
    cyc("done4", 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 16'd0);
    cyc("launch5", 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd0);
    cyc("pre_rst", 0, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00, 8'hFF, 1, 0, 16'd0);

    // Asynchronous reset mid-cycle while grants are active.
    req = 8'hFF; xreq = 8'h00; launch = 1'b0;
    #2 rst = 1'b0;
    #1;
    push_exp(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
    compare_front("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("post_rst1", 0, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 16'd0);
    cyc("post_rst2", 0, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 16'd0);

    if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
